instruction_fetch_unit: RTL

//  Upstream neighbour of control_unit. Holds the PC, fetches 32-bit instructions from instruction memory

---
 rtl/instruction_fetch_unit.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/instruction_fetch_unit.sv
// -----------------------------------------------------------------------------
// instruction_fetch_unit
//   Holds the program counter and fetches instructions from instruction memory
//   over a req/gnt/rvalid handshake. Only one memory request is outstanding at
//   a time. Each fetched instruction is presented to the control unit over a
//   valid/ready handshake, and the control unit can redirect the PC.
//
// Ports
//   clock        rising-edge clock
//   reset        asynchronous active-low reset
//   mem_req      fetch request; mem_addr is valid while high
//   mem_addr     fetch address (current PC)
//   mem_gnt      memory accepts the request this cycle
//   mem_rvalid   read data valid, one pulse per granted request
//   mem_rdata    instruction data, qualified by mem_rvalid
//   I            instruction register presented to the control unit
//   pc_out       address of the instruction held in I
//   i_valid      I/pc_out hold a valid instruction
//   i_ready      control unit consumes I this cycle
//   pc_load      redirect request; pc_in becomes the next fetch address
//   pc_in        redirect target; bits [1:0] are forced to zero
//
// state  | meaning
// -------+-----------------------------------------------------------------
// IDLE   | first cycle after reset release, no request yet
// FETCH  | mem_req high, waiting for mem_gnt
// WAIT   | request granted, waiting for mem_rvalid (drop_q: discard it)
// FULL   | instruction held in I, waiting for the control unit to take it
// -----------------------------------------------------------------------------
module instruction_fetch_unit #(
  parameter int unsigned          PC_WIDTH    = 64,
  parameter int unsigned          INSTR_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0]  RESET_PC    = '0,
  parameter int unsigned          PC_STEP     = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  output logic                   mem_req,
  output logic [PC_WIDTH-1:0]    mem_addr,
  input  logic                   mem_gnt,
  input  logic                   mem_rvalid,
  input  logic [INSTR_WIDTH-1:0] mem_rdata,
  output logic [INSTR_WIDTH-1:0] I,
  output logic [PC_WIDTH-1:0]    pc_out,
  output logic                   i_valid,
  input  logic                   i_ready,
  input  logic                   pc_load,
  input  logic [PC_WIDTH-1:0]    pc_in
);

  localparam logic [PC_WIDTH-1:0] PC_INC     = PC_WIDTH'(PC_STEP);
  localparam logic [PC_WIDTH-1:0] ALIGN_MASK = ~PC_WIDTH'(3);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_FULL
  } state_e;

  state_e                 state_q, state_d;
  logic [PC_WIDTH-1:0]    pc_q, pc_d;
  logic [PC_WIDTH-1:0]    fetch_addr_q, fetch_addr_d;
  logic [INSTR_WIDTH-1:0] instr_q, instr_d;
  logic [PC_WIDTH-1:0]    pc_out_q, pc_out_d;
  logic                   i_valid_q, i_valid_d;
  logic                   drop_q, drop_d;
  logic [PC_WIDTH-1:0]    redirect_pc;

  assign redirect_pc = pc_in & ALIGN_MASK;

  // Memory-side outputs depend only on registered state, never on inputs.
  assign mem_req  = (state_q == S_FETCH);
  assign mem_addr = pc_q;
  assign I        = instr_q;
  assign pc_out   = pc_out_q;
  assign i_valid  = i_valid_q;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    fetch_addr_d = fetch_addr_q;
    instr_d      = instr_q;
    pc_out_d     = pc_out_q;
    i_valid_d    = i_valid_q;
    drop_d       = drop_q;

    case (state_q)
      S_IDLE: begin
        state_d = S_FETCH;
        if (pc_load) pc_d = redirect_pc;
      end

      S_FETCH: begin
        if (pc_load) begin
          pc_d = redirect_pc;
          // A grant in the redirect cycle still produces a response that
          // must be swallowed before the next request goes out.
          if (mem_gnt) begin
            drop_d  = 1'b1;
            state_d = S_WAIT;
          end
        end else if (mem_gnt) begin
          fetch_addr_d = pc_q;
          pc_d         = pc_q + PC_INC;
          state_d      = S_WAIT;
        end
      end

      S_WAIT: begin
        if (pc_load) begin
          pc_d = redirect_pc;
          if (mem_rvalid) begin
            drop_d  = 1'b0;
            state_d = S_FETCH;
          end else begin
            drop_d = 1'b1;
          end
        end else if (mem_rvalid) begin
          if (drop_q) begin
            drop_d  = 1'b0;
            state_d = S_FETCH;
          end else begin
            instr_d   = mem_rdata;
            pc_out_d  = fetch_addr_q;
            i_valid_d = 1'b1;
            state_d   = S_FULL;
          end
        end
      end

      S_FULL: begin
        // A redirect flushes I; a same-cycle i_ready still counts as consumed.
        if (pc_load || (i_valid_q && i_ready)) begin
          i_valid_d = 1'b0;
          state_d   = S_FETCH;
          if (pc_load) pc_d = redirect_pc;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      pc_q         <= RESET_PC;
      fetch_addr_q <= RESET_PC;
      instr_q      <= '0;
      pc_out_q     <= '0;
      i_valid_q    <= 1'b0;
      drop_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      fetch_addr_q <= fetch_addr_d;
      instr_q      <= instr_d;
      pc_out_q     <= pc_out_d;
      i_valid_q    <= i_valid_d;
      drop_q       <= drop_d;
    end
  end

endmodule
